// File: rtl/retire_unit.sv
// retire_unit: writeback/retire stage behind execute.
//   Commits register writes and stores for instructions whose tag matches the
//   current stream tag. Instructions with any other tag are squashed. A taken
//   jump redirects fetch and advances the tag.
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   valid_in/ready_out handshake with execute (inputs held while stalled)
//   result0_in/1_in    data/link value, target/store address
//   jump_in, tag_in, we_in, rd_in, write_in  instruction attributes
//   reg_we/addr/data   register file write port (single-cycle pulse)
//   mem_write/address/data, mem_ack  store port; held until acknowledged
//   redirect/redirect_pc  fetch restart pulse and target
//   curr_tag           current stream tag
// Optional feature: define RETIRE_STATS_EN to add the retired_cnt and
//   squashed_cnt outputs.
module retire_unit #(
  parameter int unsigned TAG_W    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [31:0]      result0_in,
  input  logic [31:0]      result1_in,
  input  logic             jump_in,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             we_in,
  input  logic [4:0]       rd_in,
  input  logic [3:0]       write_in,
  output logic             reg_we,
  output logic [4:0]       reg_addr,
  output logic [31:0]      reg_data,
  output logic [3:0]       mem_write,
  output logic [31:0]      mem_address,
  output logic [31:0]      mem_data,
  input  logic             mem_ack,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic [TAG_W-1:0] curr_tag
`ifdef RETIRE_STATS_EN
  ,
  output logic [31:0]      retired_cnt,
  output logic [31:0]      squashed_cnt
`endif
);

  typedef enum logic {IDLE = 1'b0, STORE = 1'b1} state_t;

  state_t           state_q, state_d;
  logic             ready_q, ready_d;
  logic             reg_we_q, reg_we_d;
  logic [4:0]       reg_addr_q, reg_addr_d;
  logic [31:0]      reg_data_q, reg_data_d;
  logic [3:0]       mem_write_q, mem_write_d;
  logic [31:0]      mem_address_q, mem_address_d;
  logic [31:0]      mem_data_q, mem_data_d;
  logic             redirect_q, redirect_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic accept_c;
  logic live_c;

  assign accept_c = valid_in && ready_q;
  assign live_c   = accept_c && (tag_in == tag_q);

  // Next-state and output computation.
  always_comb begin
    state_d       = state_q;
    reg_we_d      = 1'b0;
    reg_addr_d    = reg_addr_q;
    reg_data_d    = reg_data_q;
    mem_write_d   = mem_write_q;
    mem_address_d = mem_address_q;
    mem_data_d    = mem_data_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    tag_d         = tag_q;

    case (state_q)
      IDLE: begin
        if (live_c) begin
          if (we_in && (rd_in != 5'd0)) begin
            reg_we_d   = 1'b1;
            reg_addr_d = rd_in;
            reg_data_d = result0_in;
          end
          // Jump wins over a (malformed) simultaneous store.
          if (jump_in) begin
            redirect_d    = 1'b1;
            redirect_pc_d = result1_in;
            tag_d         = tag_q + TAG_W'(1);
          end else if (write_in != 4'd0) begin
            state_d       = STORE;
            mem_write_d   = write_in;
            mem_address_d = result1_in;
            mem_data_d    = result0_in;
          end
        end
      end
      STORE: begin
        if (mem_ack) begin
          state_d     = IDLE;
          mem_write_d = 4'd0;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      ready_q       <= 1'b1;
      reg_we_q      <= 1'b0;
      reg_addr_q    <= 5'd0;
      reg_data_q    <= 32'd0;
      mem_write_q   <= 4'd0;
      mem_address_q <= 32'd0;
      mem_data_q    <= 32'd0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= RESET_PC;
      tag_q         <= '0;
    end else begin
      state_q       <= state_d;
      ready_q       <= ready_d;
      reg_we_q      <= reg_we_d;
      reg_addr_q    <= reg_addr_d;
      reg_data_q    <= reg_data_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_data_q    <= mem_data_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      tag_q         <= tag_d;
    end
  end

  assign ready_out   = ready_q;
  assign reg_we      = reg_we_q;
  assign reg_addr    = reg_addr_q;
  assign reg_data    = reg_data_q;
  assign mem_write   = mem_write_q;
  assign mem_address = mem_address_q;
  assign mem_data    = mem_data_q;
  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;
  assign curr_tag    = tag_q;

`ifdef RETIRE_STATS_EN
  logic [31:0] retired_cnt_q, retired_cnt_d;
  logic [31:0] squashed_cnt_q, squashed_cnt_d;

  // Accept statistics; both wrap naturally.
  always_comb begin
    retired_cnt_d  = retired_cnt_q;
    squashed_cnt_d = squashed_cnt_q;
    if (live_c) begin
      retired_cnt_d = retired_cnt_q + 32'd1;
    end else if (accept_c) begin
      squashed_cnt_d = squashed_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_cnt_q  <= 32'd0;
      squashed_cnt_q <= 32'd0;
    end else begin
      retired_cnt_q  <= retired_cnt_d;
      squashed_cnt_q <= squashed_cnt_d;
    end
  end

  assign retired_cnt  = retired_cnt_q;
  assign squashed_cnt = squashed_cnt_q;
`endif

endmodule

// File: tb/tb_retire_unit.sv
// Testbench for retire_unit: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction model.
module tb_retire_unit;

  localparam int unsigned TAG_W    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_1000;
  localparam int          NTAGS    = 1 << TAG_W;

  logic             clk = 1'b0;
  logic             reset;
  logic             valid_in;
  logic             ready_out;
  logic [31:0]      result0_in, result1_in;
  logic             jump_in;
  logic [TAG_W-1:0] tag_in;
  logic             we_in;
  logic [4:0]       rd_in;
  logic [3:0]       write_in;
  logic             reg_we;
  logic [4:0]       reg_addr;
  logic [31:0]      reg_data;
  logic [3:0]       mem_write;
  logic [31:0]      mem_address, mem_data;
  logic             mem_ack;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic [TAG_W-1:0] curr_tag;
`ifdef RETIRE_STATS_EN
  logic [31:0]      retired_cnt, squashed_cnt;
`endif

  retire_unit #(.TAG_W(TAG_W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(ready_out),
    .result0_in(result0_in), .result1_in(result1_in), .jump_in(jump_in),
    .tag_in(tag_in), .we_in(we_in), .rd_in(rd_in), .write_in(write_in),
    .reg_we(reg_we), .reg_addr(reg_addr), .reg_data(reg_data),
    .mem_write(mem_write), .mem_address(mem_address), .mem_data(mem_data),
    .mem_ack(mem_ack), .redirect(redirect), .redirect_pc(redirect_pc),
    .curr_tag(curr_tag)
`ifdef RETIRE_STATS_EN
    , .retired_cnt(retired_cnt), .squashed_cnt(squashed_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Transaction-level model: retired instruction effects as seen next cycle.
  bit          m_ready;
  bit          m_reg_we;
  logic [4:0]  m_reg_addr;
  logic [31:0] m_reg_data;
  logic [3:0]  m_mem_write;
  logic [31:0] m_mem_addr, m_mem_data;
  bit          m_redirect;
  logic [31:0] m_pc;
  int          m_tag;
  logic [31:0] m_ret, m_sq;

  always @(posedge clk) begin
    bit acc, live;
    if (reset) begin
      m_ready = 1; m_reg_we = 0; m_reg_addr = 0; m_reg_data = 0;
      m_mem_write = 0; m_mem_addr = 0; m_mem_data = 0;
      m_redirect = 0; m_pc = RESET_PC; m_tag = 0; m_ret = 0; m_sq = 0;
    end else begin
      acc  = valid_in && m_ready;
      live = acc && (int'(tag_in) == m_tag);
      m_reg_we   = 0;
      m_redirect = 0;
      if (!m_ready) begin
        if (mem_ack) begin
          m_mem_write = 0;
          m_ready     = 1;
        end
      end else if (live) begin
        if (we_in && rd_in != 0) begin
          m_reg_we = 1; m_reg_addr = rd_in; m_reg_data = result0_in;
        end
        if (jump_in) begin
          m_redirect = 1; m_pc = result1_in; m_tag = (m_tag + 1) % NTAGS;
        end else if (write_in != 0) begin
          m_mem_write = write_in; m_mem_addr = result1_in; m_mem_data = result0_in;
          m_ready = 0;
        end
      end
      if (live) m_ret = m_ret + 1;
      else if (acc) m_sq = m_sq + 1;
    end
    #1;
    chk("ready_out", 32'(ready_out), 32'(m_ready));
    chk("reg_we", 32'(reg_we), 32'(m_reg_we));
    chk("reg_addr", 32'(reg_addr), 32'(m_reg_addr));
    chk("reg_data", reg_data, m_reg_data);
    chk("mem_write", 32'(mem_write), 32'(m_mem_write));
    chk("mem_address", mem_address, m_mem_addr);
    chk("mem_data", mem_data, m_mem_data);
    chk("redirect", 32'(redirect), 32'(m_redirect));
    chk("redirect_pc", redirect_pc, m_pc);
    chk("curr_tag", 32'(curr_tag), 32'(m_tag));
`ifdef RETIRE_STATS_EN
    chk("retired_cnt", retired_cnt, m_ret);
    chk("squashed_cnt", squashed_cnt, m_sq);
`endif
  end

  task automatic drive(input bit v, input int tag, input bit j, input bit we,
                       input int rd, input int w, input logic [31:0] r0,
                       input logic [31:0] r1);
    valid_in   = v;
    tag_in     = TAG_W'(tag);
    jump_in    = j;
    we_in      = we;
    rd_in      = 5'(rd);
    write_in   = 4'(w);
    result0_in = r0;
    result1_in = r1;
  endtask

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  logic [3:0] tag_seq [16] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8,
                               4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd0};

  initial begin
    reset = 1'b1;
    mem_ack = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    #1;
    chk("rst ready", 32'(ready_out), 32'd1);
    chk("rst redirect_pc", redirect_pc, RESET_PC);
    chk("rst mem_write", 32'(mem_write), 32'd0);

    // ALU write, then rd=0 never writes
    @(negedge clk) drive(1, 0, 0, 1, 5, 0, 32'h1234, 32'h0);
    step();
    chk("alu reg_we", 32'(reg_we), 32'd1);
    chk("alu reg_addr", 32'(reg_addr), 32'd5);
    chk("alu reg_data", reg_data, 32'h1234);
    @(negedge clk) drive(1, 0, 0, 1, 0, 0, 32'h5555, 32'h0);
    step();
    chk("rd0 reg_we", 32'(reg_we), 32'd0);

    // JAL, then stale-tag instruction squashed
    @(negedge clk) drive(1, 0, 1, 1, 1, 0, 32'h104, 32'h200);
    step();
    chk("jal redirect", 32'(redirect), 32'd1);
    chk("jal redirect_pc", redirect_pc, 32'h200);
    chk("jal reg_data", reg_data, 32'h104);
    chk("jal curr_tag", 32'(curr_tag), 32'd1);
    @(negedge clk) drive(1, 0, 0, 1, 7, 0, 32'h77, 32'h0);
    step();
    chk("squash reg_we", 32'(reg_we), 32'd0);
    chk("squash redirect", 32'(redirect), 32'd0);
    chk("squash ready", 32'(ready_out), 32'd1);

    // Store with ack after three stalled cycles; next instruction held
    @(negedge clk) drive(1, 1, 0, 0, 0, 3, 32'hBEEF, 32'h80);
    step();
    @(negedge clk) drive(1, 1, 0, 1, 9, 0, 32'h99, 32'h0);
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("st mem_write", 32'(mem_write), 32'd3);
      chk("st mem_address", mem_address, 32'h80);
      chk("st mem_data", mem_data, 32'hBEEF);
      chk("st ready", 32'(ready_out), 32'd0);
      if (i == 2) mem_ack = 1'b1;
      step();
      chk("st no reg_we", 32'(reg_we), 32'd0);
    end
    chk("ack mem_write", 32'(mem_write), 32'd0);
    chk("ack ready", 32'(ready_out), 32'd1);
    @(negedge clk) mem_ack = 1'b0;
    step();
    chk("held reg_we", 32'(reg_we), 32'd1);
    chk("held reg_addr", 32'(reg_addr), 32'd9);
    chk("held reg_data", reg_data, 32'h99);

    // Reset in the middle of a pending store
    @(negedge clk) drive(1, 1, 0, 0, 0, 15, 32'h1, 32'h40);
    step();
    chk("pre-rst mem_write", 32'(mem_write), 32'hF);
    @(negedge clk) begin
      drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
      reset = 1'b1;
    end
    #1;
    chk("rst mid mem_write", 32'(mem_write), 32'd0);
    chk("rst mid ready", 32'(ready_out), 32'd1);
    chk("rst mid curr_tag", 32'(curr_tag), 32'd0);
    @(negedge clk) reset = 1'b0;

    // Sixteen jumps walk the tag around the ring; 17th with tag 0 is live
    for (int i = 0; i < 16; i++) begin
      @(negedge clk) drive(1, i, 1, 0, 0, 0, 32'h0, 32'h100 + 32'(i));
      step();
      chk("wrap redirect", 32'(redirect), 32'd1);
      chk("wrap curr_tag", 32'(curr_tag), 32'(tag_seq[i]));
    end
    @(negedge clk) drive(1, 0, 1, 0, 0, 0, 32'h0, 32'h900);
    step();
    chk("wrap17 redirect", 32'(redirect), 32'd1);
    chk("wrap17 pc", redirect_pc, 32'h900);
    chk("wrap17 curr_tag", 32'(curr_tag), 32'd1);

    // Randomized traffic; upstream holds while stalled
    @(negedge clk) drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      mem_ack = ($urandom_range(0, 2) == 0);
      if (!(valid_in && !ready_out)) begin
        drive($urandom_range(0, 3) != 0,
              ($urandom_range(0, 4) < 3) ? m_tag : int'($urandom_range(0, NTAGS - 1)),
              $urandom_range(0, 4) == 0,
              $urandom_range(0, 1) == 1,
              int'($urandom_range(0, 31)),
              ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : 0,
              $urandom, $urandom);
      end
    end

`ifdef RETIRE_STATS_EN
    // Counter check from a clean reset: 3 live, 2 squashed
    @(negedge clk) begin
      drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
      mem_ack = 1'b0;
      reset = 1'b1;
    end
    @(negedge clk) reset = 1'b0;
    @(negedge clk) drive(1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    @(negedge clk) drive(1, 5, 0, 0, 0, 0, 32'h0, 32'h0);
    @(negedge clk) drive(1, 0, 0, 1, 3, 0, 32'h3, 32'h0);
    @(negedge clk) drive(1, 7, 0, 0, 0, 0, 32'h0, 32'h0);
    @(negedge clk) drive(1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    @(negedge clk) drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    #1;
    chk("stats retired", retired_cnt, 32'd3);
    chk("stats squashed", squashed_cnt, 32'd2);
`endif

    repeat (2) @(posedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
